// File: rtl/data_mem_pkg.sv
// Shared CPU constants: store-op encodings and default data-memory geometry.
package data_mem_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned DM_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        SOP_SW   = 2'b00,
        SOP_SB   = 2'b01,
        SOP_SH   = 2'b10,
        SOP_RSVD = 2'b11
    } sop_e;

endpackage

// File: rtl/data_mem_if.sv
// Load/store port between the pipeline (master) and the data memory (slave).
interface data_mem_if;
    import data_mem_pkg::*;

    logic            WE;
    logic [1:0]      SOp;
    logic [XLEN-1:0] Addr;
    logic [XLEN-1:0] WData;
    logic [XLEN-1:0] RData;
    logic [3:0]      ByteEn;
    logic            StoreErr;

    modport master (output WE, SOp, Addr, WData, input RData, ByteEn, StoreErr);
    modport slave  (input WE, SOp, Addr, WData, output RData, ByteEn, StoreErr);
endinterface

// File: rtl/dm_be_gen.sv
// Store lane decode: byte enables, lane-replicated write data and store legality.
module dm_be_gen
    import data_mem_pkg::*;
(
    input  logic            we,
    input  logic [1:0]      sop,
    input  logic [1:0]      addr_lo,
    input  logic            in_range,
    input  logic [XLEN-1:0] wdata,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] wdata_lanes,
    output logic            illegal
);

    logic [3:0] lanes;

    always_comb begin
        lanes       = 4'b0000;
        wdata_lanes = wdata;
        illegal     = !in_range;
        unique case (sop_e'(sop))
            SOP_SW: begin
                lanes = 4'b1111;
                if (addr_lo != 2'b00) illegal = 1'b1;
            end
            SOP_SB: begin
                lanes       = 4'(4'b0001 << addr_lo);
                wdata_lanes = {4{wdata[7:0]}};
            end
            SOP_SH: begin
                lanes       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                if (addr_lo[0]) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // A dropped store must not touch any lane.
        byte_en = (we && !illegal) ? lanes : 4'b0000;
    end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory: combinational read, byte-lane store, sticky store error.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    data_mem_if.slave   bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    logic [XLEN-1:0]       mem [DEPTH];
    logic [XLEN-1:0]       offset;
    logic [ADDR_WIDTH-1:0] index;
    logic                  in_range;
    logic [3:0]            byte_en;
    logic [XLEN-1:0]       wdata_lanes;
    logic                  illegal;
    logic                  store_err;

    assign offset   = bus.Addr - BASE_ADDR;
    assign index    = offset[ADDR_WIDTH+1:2];
    assign in_range = 33'(offset) < SPAN;

    dm_be_gen u_be_gen (
        .we          (bus.WE),
        .sop         (bus.SOp),
        .addr_lo     (bus.Addr[1:0]),
        .in_range    (in_range),
        .wdata       (bus.WData),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .illegal     (illegal)
    );

    assign bus.RData    = in_range ? mem[index] : '0;
    assign bus.ByteEn   = byte_en;
    assign bus.StoreErr = store_err;

    // Reset wipes the whole array in one edge and wins over any concurrent store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= '0;
            end
            store_err <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[index][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
            if (bus.WE && illegal) store_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: store lanes, legality, sticky error, reset and read timing.
module tb_data_mem;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    data_mem_if bus ();

    data_mem #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sop,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.WE    = we;
        bus.SOp   = sop;
        bus.Addr  = addr;
        bus.WData = wdata;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        do_reset();

        // Reset state
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        check("rst_rdata", bus.RData, 32'h0);
        check("rst_err", {31'h0, bus.StoreErr}, 32'h0);
        check("idle_be", {28'h0, bus.ByteEn}, 32'h0);

        // sw then sb on the same word
        drive(1'b1, 2'b00, 32'h10, 32'h1234_5678);
        check("sw_be", {28'h0, bus.ByteEn}, 32'hF);
        check("sw_rbw", bus.RData, 32'h0);
        tick();
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        check("sw_rd", bus.RData, 32'h1234_5678);

        drive(1'b1, 2'b01, 32'h13, 32'h0000_00AB);
        check("sb3_be", {28'h0, bus.ByteEn}, 32'h8);
        tick();
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        check("sb3_rd", bus.RData, 32'hAB34_5678);

        drive(1'b1, 2'b01, 32'h11, 32'hFFFF_FFCD);
        check("sb1_be", {28'h0, bus.ByteEn}, 32'h2);
        tick();
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        check("sb1_rd", bus.RData, 32'hAB34_CD78);
        check("sb_err", {31'h0, bus.StoreErr}, 32'h0);

        // Halfword stores onto a cleared word
        do_reset();
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        check("clr_rd", bus.RData, 32'h0);
        drive(1'b1, 2'b10, 32'h12, 32'h0000_BEEF);
        check("sh_hi_be", {28'h0, bus.ByteEn}, 32'hC);
        tick();
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        check("sh_hi_rd", bus.RData, 32'hBEEF_0000);

        drive(1'b1, 2'b10, 32'h10, 32'h1234_CAFE);
        check("sh_lo_be", {28'h0, bus.ByteEn}, 32'h3);
        tick();
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        check("sh_lo_rd", bus.RData, 32'hBEEF_CAFE);

        drive(1'b1, 2'b10, 32'h11, 32'h0000_1111);
        check("sh_mis_be", {28'h0, bus.ByteEn}, 32'h0);
        check("sh_mis_err0", {31'h0, bus.StoreErr}, 32'h0);
        tick();
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        check("sh_mis_rd", bus.RData, 32'hBEEF_CAFE);
        check("sh_mis_err", {31'h0, bus.StoreErr}, 32'h1);

        // Out-of-range store, then reset clears the error
        do_reset();
        check("err_clr", {31'h0, bus.StoreErr}, 32'h0);
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        check("clr_rd2", bus.RData, 32'h0);
        drive(1'b1, 2'b00, 32'h4000, 32'hFFFF_FFFF);
        check("oor_be", {28'h0, bus.ByteEn}, 32'h0);
        tick();
        drive(1'b0, 2'b00, 32'h4000, 32'h0);
        check("oor_rd", bus.RData, 32'h0);
        check("oor_err", {31'h0, bus.StoreErr}, 32'h1);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("oor_alias", bus.RData, 32'h0);
        do_reset();
        check("oor_err_clr", {31'h0, bus.StoreErr}, 32'h0);

        // Last in-range word
        drive(1'b1, 2'b00, 32'h3FFC, 32'hA5A5_5A5A);
        check("top_be", {28'h0, bus.ByteEn}, 32'hF);
        tick();
        drive(1'b0, 2'b00, 32'h3FFC, 32'h0);
        check("top_rd", bus.RData, 32'hA5A5_5A5A);
        check("top_err", {31'h0, bus.StoreErr}, 32'h0);

        // Idle cycle with garbage inputs must not change state
        drive(1'b0, 2'b11, 32'h3FFE, 32'h1111_1111);
        tick();
        drive(1'b0, 2'b00, 32'h3FFC, 32'h0);
        check("idle_rd", bus.RData, 32'hA5A5_5A5A);
        check("idle_err", {31'h0, bus.StoreErr}, 32'h0);

        // Misaligned sw and reserved op
        drive(1'b1, 2'b00, 32'h32, 32'hFFFF_FFFF);
        check("sw_mis_be", {28'h0, bus.ByteEn}, 32'h0);
        drive(1'b1, 2'b11, 32'h30, 32'hFFFF_FFFF);
        check("rsvd_be", {28'h0, bus.ByteEn}, 32'h0);
        tick();
        drive(1'b0, 2'b00, 32'h30, 32'h0);
        check("rsvd_rd", bus.RData, 32'h0);
        check("rsvd_err", {31'h0, bus.StoreErr}, 32'h1);

        // Reset beats a simultaneous store
        reset = 1'b1;
        drive(1'b1, 2'b00, 32'h20, 32'hFFFF_FFFF);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h20, 32'h0);
        check("rst_st_rd", bus.RData, 32'h0);
        check("rst_st_err", {31'h0, bus.StoreErr}, 32'h0);
        drive(1'b0, 2'b00, 32'h3FFC, 32'h0);
        check("rst_top_rd", bus.RData, 32'h0);

        // Read-before-write
        drive(1'b1, 2'b00, 32'h30, 32'hDEAD_BEEF);
        check("rbw_old", bus.RData, 32'h0);
        tick();
        drive(1'b0, 2'b00, 32'h30, 32'h0);
        check("rbw_new", bus.RData, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
